dmem_resp: RTL and testbench

Data-memory responder for the five-stage core: the memory-side end of the interface driven by the memory stage. It accepts one word-aligned, byte-masked read or write request per cycle and returns read data with a parameterized latency of 0 or 1 cycles. It flags protocol and range faults with a sticky error and first-fault address. It also counts completed accesses for the testbench and performance reporting.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/bram_be.sv | 31 +++
 rtl/dmem_resp.sv | 108 ++++++++++
 tb/tb_dmem_resp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and the address range predicate for the data memory.
package dmem_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = 32;

  // 33-bit compare so a window ending at 2^32 cannot overflow.
  function automatic logic in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 2);
    return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/bram_be.sv
// Word array with one byte-enabled write port and one async read port.
module bram_be
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int n = 0; n < LANES; n++) begin
        if (be[n]) begin
          mem[waddr][LANE_W*n +: LANE_W] <= wdata[LANE_W*n +: LANE_W];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: range check, byte-masked array, read response,
// sticky fault capture and access counters.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          READ_LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_dmem_addr,
  input  logic [WORD_W-1:0] i_dmem_wdata,
  input  logic [LANES-1:0]  i_dmem_mask,
  input  logic              i_dmem_wen,
  input  logic              i_dmem_ren,
  output logic [WORD_W-1:0] o_dmem_rdata,
  output logic              o_rvld,
  output logic              o_err,
  output logic [31:0]       o_err_addr,
  output logic [31:0]       o_rd_cnt,
  output logic [31:0]       o_wr_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic              ok;
  logic [31:0]       off;
  logic [AW-1:0]     idx;
  logic              we;
  logic              fault;
  logic [WORD_W-1:0] rd;

  assign ok    = in_range(i_dmem_addr, BASE_ADDR, DEPTH_WORDS);
  assign off   = i_dmem_addr - BASE_ADDR;
  assign idx   = AW'(off >> 2);
  assign we    = i_dmem_wen & ok & ~i_rst;
  assign fault = (i_dmem_ren | i_dmem_wen)
               & (~ok | (i_dmem_ren & i_dmem_wen));

  bram_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (i_clk),
    .we    (we),
    .be    (i_dmem_mask),
    .waddr (idx),
    .wdata (i_dmem_wdata),
    .raddr (idx),
    .rdata (rd)
  );

  generate
    if (READ_LAT == 0) begin : g_lat0
      // Old word only: the array write lands at the edge.
      assign o_dmem_rdata = (i_dmem_ren & ok) ? rd : '0;
      assign o_rvld       = i_dmem_ren & ~i_rst;
    end else begin : g_lat1
      logic [WORD_W-1:0] merged;

      always_comb begin
        merged = rd;
        if (we) begin
          for (int n = 0; n < LANES; n++) begin
            if (i_dmem_mask[n]) begin
              merged[LANE_W*n +: LANE_W] = i_dmem_wdata[LANE_W*n +: LANE_W];
            end
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          o_dmem_rdata <= '0;
          o_rvld       <= 1'b0;
        end else begin
          o_rvld <= i_dmem_ren;
          if (i_dmem_ren) begin
            o_dmem_rdata <= ok ? merged : '0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err      <= 1'b0;
      o_err_addr <= '0;
      o_rd_cnt   <= '0;
      o_wr_cnt   <= '0;
    end else begin
      if (fault) begin
        o_err <= 1'b1;
        if (!o_err) begin
          o_err_addr <= i_dmem_addr;
        end
      end
      if (i_dmem_ren && ok) begin
        o_rd_cnt <= o_rd_cnt + 32'd1;
      end
      if (i_dmem_wen && ok) begin
        o_wr_cnt <= o_wr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed plus randomized bench for dmem_resp, both read latencies.
module tb_dmem_resp;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        wen;
  logic        ren;

  logic [31:0] rdata1, err_addr1, rd_cnt1, wr_cnt1;
  logic        rvld1, err1;
  logic [31:0] rdata0, err_addr0, rd_cnt0, wr_cnt0;
  logic        rvld0, err0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata1;
  logic        m_rvld1;
  logic        m_err;
  logic [31:0] m_err_addr;
  logic [31:0] m_rd_cnt;
  logic [31:0] m_wr_cnt;
  logic [31:0] last_rdata0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_dmem_addr(addr), .i_dmem_wdata(wdata),
    .i_dmem_mask(mask), .i_dmem_wen(wen), .i_dmem_ren(ren),
    .o_dmem_rdata(rdata1), .o_rvld(rvld1), .o_err(err1),
    .o_err_addr(err_addr1), .o_rd_cnt(rd_cnt1), .o_wr_cnt(wr_cnt1)
  );

  dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_dmem_addr(addr), .i_dmem_wdata(wdata),
    .i_dmem_mask(mask), .i_dmem_wen(wen), .i_dmem_ren(ren),
    .o_dmem_rdata(rdata0), .o_rvld(rvld0), .o_err(err0),
    .o_err_addr(err_addr0), .o_rd_cnt(rd_cnt0), .o_wr_cnt(wr_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive, check the combinational response,
  // clock, then check registered outputs against the model.
  task automatic step(input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      input bit rs);
    longint      la;
    bit          in_rng;
    int          ix;
    logic [31:0] old_w;
    logic [31:0] new_w;
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d; mask = m; rst = rs;
    la     = longint'(a);
    in_rng = (la < 4 * DEPTH) && (la % 4 == 0);
    ix     = in_rng ? int'(la / 4) : 0;
    old_w  = m_mem[ix];
    new_w  = old_w;
    if (w && in_rng && !rs) begin
      for (int n = 0; n < 4; n++)
        if (m[n]) new_w[8*n +: 8] = d[8*n +: 8];
    end
    #1;
    last_rdata0 = rdata0;
    chk("lat0_rvld", {31'd0, rvld0}, {31'd0, r && !rs});
    if (r && !rs) chk("lat0_rdata", rdata0, in_rng ? old_w : 32'h0);
    @(posedge clk);
    if (w && in_rng && !rs) m_mem[ix] = new_w;
    if (rs) begin
      m_rdata1 = 32'h0; m_rvld1 = 1'b0; m_err = 1'b0;
      m_err_addr = 32'h0; m_rd_cnt = 32'h0; m_wr_cnt = 32'h0;
    end else begin
      m_rvld1 = r;
      if (r) m_rdata1 = in_rng ? new_w : 32'h0;
      if ((r || w) && (!in_rng || (r && w))) begin
        if (!m_err) m_err_addr = a;
        m_err = 1'b1;
      end
      if (r && in_rng) m_rd_cnt = m_rd_cnt + 32'd1;
      if (w && in_rng) m_wr_cnt = m_wr_cnt + 32'd1;
    end
    #1;
    chk("lat1_rdata", rdata1, m_rdata1);
    chk("lat1_rvld", {31'd0, rvld1}, {31'd0, m_rvld1});
    chk("err", {31'd0, err1}, {31'd0, m_err});
    chk("err_addr", err_addr1, m_err_addr);
    chk("rd_cnt", rd_cnt1, m_rd_cnt);
    chk("wr_cnt", wr_cnt1, m_wr_cnt);
    chk("lat0_err_addr", err_addr0, m_err_addr);
    chk("lat0_wr_cnt", wr_cnt0, m_wr_cnt);
  endtask

  initial begin
    logic [31:0] ra;
    int          sel;
    rst = 1'b1; ren = 1'b0; wen = 1'b0;
    addr = '0; wdata = '0; mask = '0;
    m_rdata1 = '0; m_rvld1 = 1'b0; m_err = 1'b0;
    m_err_addr = '0; m_rd_cnt = '0; m_wr_cnt = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

    // reset
    step(0, 0, 32'h0, 32'h0, 4'h0, 1);
    step(0, 0, 32'h0, 32'h0, 4'h0, 1);
    chk("rst_rvld", {31'd0, rvld1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_err_addr", err_addr1, 32'h0);
    chk("rst_rd_cnt", rd_cnt1, 32'h0);
    chk("rst_wr_cnt", wr_cnt1, 32'h0);
    chk("rst_rdata", rdata1, 32'h0);

    // give every word a known value, then clear counters
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 32'(i * 4), 32'h0, 4'hF, 0);
    step(0, 0, 32'h0, 32'h0, 4'h0, 1);

    // byte-mask merge
    step(0, 1, 32'h10, 32'h1122_3344, 4'hF, 0);
    step(0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0);
    step(1, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("merge_rdata", rdata1, 32'h11BB_33DD);
    chk("merge_rvld", {31'd0, rvld1}, 32'd1);
    chk("merge_wr_cnt", wr_cnt1, 32'd2);
    chk("merge_rd_cnt", rd_cnt1, 32'd1);

    // same-cycle read and write
    step(1, 1, 32'h20, 32'hDEAD_BEEF, 4'b1100, 0);
    chk("rw_lat1", rdata1, 32'hDEAD_0000);
    chk("rw_lat0", last_rdata0, 32'h0);
    chk("rw_err", {31'd0, err1}, 32'd1);
    chk("rw_err_addr", err_addr1, 32'h20);

    // range and alignment faults
    step(0, 0, 32'h0, 32'h0, 4'h0, 1);
    step(0, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
    chk("oor_wr_cnt", wr_cnt1, 32'd0);
    chk("oor_err", {31'd0, err1}, 32'd1);
    chk("oor_err_addr", err_addr1, 32'h1000);
    step(1, 0, 32'h2, 32'h0, 4'h0, 0);
    chk("mis_rdata", rdata1, 32'h0);
    chk("mis_lat0", last_rdata0, 32'h0);
    chk("mis_err_addr", err_addr1, 32'h1000);
    step(1, 0, 32'h0, 32'h0, 4'h0, 0);
    chk("oor_array", rdata1, 32'h0);

    // reset in the middle of traffic
    step(0, 1, 32'h8, 32'h1234_5678, 4'hF, 0);
    step(0, 1, 32'h8, 32'h5555_5555, 4'hF, 1);
    step(1, 0, 32'h8, 32'h0, 4'h0, 0);
    chk("rst_drop", rdata1, 32'h1234_5678);
    chk("rst_keep", rdata1 ^ 32'h5555_5555, 32'h4761_032D);

    // back-to-back
    step(0, 0, 32'h0, 32'h0, 4'h0, 1);
    for (int i = 0; i < 10; i++)
      step(0, 1, 32'(i * 4), 32'hA000_0000 + 32'(i * 3), 4'hF, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 32'(i * 4), 32'h0, 4'h0, 0);
      chk("b2b_rdata", rdata1, 32'hA000_0000 + 32'(i * 3));
    end
    chk("b2b_rd_cnt", rd_cnt1, 32'd10);
    chk("b2b_wr_cnt", wr_cnt1, 32'd10);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 85) ra = 32'($urandom_range(0, 63)) << 2;
      else if (sel < 92) ra = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      else if (sel < 97) ra = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else ra = 32'hFFFF_FFFC;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra,
           $urandom, 4'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
